// File: rtl/fabric_prog_seq_pkg.sv
// Shared geometry, default pulse timing and sequencer state encoding for the
// fabric island programming sequencer.
package fabric_prog_pkg;

  localparam int N_ROWS = 7;
  localparam int N_COLS = 7;
  localparam int ROW_W  = 3;
  localparam int COL_W  = 3;
  localparam int CNT_W  = 8;

  localparam int DEF_SETUP_CYC   = 4;
  localparam int DEF_PULSE_CYC   = 16;
  localparam int DEF_GAP_CYC     = 8;
  localparam int DEF_RELEASE_CYC = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_PULSE,
    ST_GAP,
    ST_RELEASE
  } state_e;

  // Timing counters are loaded with (cycles - 1), so every duration must fit
  // in the counter and be at least one cycle.
  function automatic bit cyc_fits(input int cyc, input int width);
    return (cyc >= 1) && (cyc < (1 << width));
  endfunction

endpackage

// File: rtl/fabric_prog_seq_if.sv
// Command and programming-mux bundle between a command source (master) and the
// sequencer (slave).
interface fabric_prog_seq_if;
  import fabric_prog_pkg::*;

  logic              cmd_valid;
  logic              cmd_ready;
  logic [ROW_W-1:0]  cmd_row;
  logic [COL_W-1:0]  cmd_col;
  logic [CNT_W-1:0]  cmd_npulse;
  logic              abort;
  logic [N_ROWS-1:0] row_sel;
  logic [N_COLS-1:0] col_sel;
  logic              prog_en;
  logic              busy;
  logic              done;
  logic              err;

  modport master (
    output cmd_valid, cmd_row, cmd_col, cmd_npulse, abort,
    input  cmd_ready, row_sel, col_sel, prog_en, busy, done, err
  );

  modport slave (
    input  cmd_valid, cmd_row, cmd_col, cmd_npulse, abort,
    output cmd_ready, row_sel, col_sel, prog_en, busy, done, err
  );

endinterface

// File: rtl/fabric_prog_seq_onehot_dec.sv
// Binary to one-hot decoder, combinational; o_vld flags an index inside 0..N-1,
// out-of-range indices decode to all zeros.
module prog_onehot_dec #(
  parameter int N     = 7,
  parameter int BIN_W = 3
) (
  input  logic [BIN_W-1:0] i_bin,
  output logic [N-1:0]     o_onehot,
  output logic             o_vld
);

  always_comb begin
    o_onehot = '0;
    for (int i = 0; i < N; i++) begin
      o_onehot[i] = (int'(i_bin) == i);
    end
  end

  assign o_vld = (int'(i_bin) < N);

endmodule

// File: rtl/fabric_prog_seq.sv
// Programming sequencer: one command -> selects, pulse train, release; done at
// SETUP+n*PULSE+(n-1)*GAP+RELEASE+1 cycles. cmd_ready only in IDLE, so a held command waits.
module fabric_prog_seq
  import fabric_prog_pkg::*;
#(
  parameter int SETUP_CYC   = DEF_SETUP_CYC,
  parameter int PULSE_CYC   = DEF_PULSE_CYC,
  parameter int GAP_CYC     = DEF_GAP_CYC,
  parameter int RELEASE_CYC = DEF_RELEASE_CYC
) (
  input  logic              clk,
  input  logic              rst_n,
  fabric_prog_seq_if.slave  bus
);

  if (!cyc_fits(SETUP_CYC, CNT_W) || !cyc_fits(PULSE_CYC, CNT_W) ||
      !cyc_fits(GAP_CYC, CNT_W)   || !cyc_fits(RELEASE_CYC, CNT_W)) begin : g_bad_timing
    $error("fabric_prog_seq: timing parameters must lie in 1..2**CNT_W-1");
  end

  localparam logic [CNT_W-1:0] SETUP_LD   = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] PULSE_LD   = CNT_W'(PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LD     = CNT_W'(GAP_CYC - 1);
  localparam logic [CNT_W-1:0] RELEASE_LD = CNT_W'(RELEASE_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  state_e            r_state, w_state;
  logic [CNT_W-1:0]  r_cnt, w_cnt;
  logic [CNT_W-1:0]  r_rem, w_rem;
  logic [N_ROWS-1:0] r_row_sel, w_row_sel, w_row_dec;
  logic [N_COLS-1:0] r_col_sel, w_col_sel, w_col_dec;
  logic              r_prog_en, w_prog_en;
  logic              r_busy, w_busy;
  logic              r_done, w_done;
  logic              r_err, w_err;
  logic              w_row_vld, w_col_vld;
  logic              w_to_rel;

  prog_onehot_dec #(.N(N_ROWS), .BIN_W(ROW_W)) u_row_dec (
    .i_bin    (bus.cmd_row),
    .o_onehot (w_row_dec),
    .o_vld    (w_row_vld)
  );

  prog_onehot_dec #(.N(N_COLS), .BIN_W(COL_W)) u_col_dec (
    .i_bin    (bus.cmd_col),
    .o_onehot (w_col_dec),
    .o_vld    (w_col_vld)
  );

  always_comb begin
    w_state   = r_state;
    w_cnt     = r_cnt;
    w_rem     = r_rem;
    w_row_sel = r_row_sel;
    w_col_sel = r_col_sel;
    w_prog_en = r_prog_en;
    w_busy    = r_busy;
    w_done    = 1'b0;
    w_err     = r_err;
    w_to_rel  = 1'b0;

    if (r_state == ST_IDLE) begin
      if (bus.cmd_valid) begin
        if (w_row_vld && w_col_vld) begin
          w_state   = ST_SETUP;
          w_cnt     = SETUP_LD;
          w_rem     = bus.cmd_npulse;
          w_row_sel = w_row_dec;
          w_col_sel = w_col_dec;
          w_busy    = 1'b1;
        end else begin
          // Out-of-range target: swallow the command and flag it.
          w_err  = 1'b1;
          w_done = 1'b1;
        end
      end
    end else if (bus.abort && (r_state != ST_RELEASE)) begin
      w_to_rel = 1'b1;
    end else if (r_cnt != '0) begin
      w_cnt = r_cnt - CNT_ONE;
    end else begin
      case (r_state)
        ST_SETUP: begin
          if (r_rem == '0) begin
            w_to_rel = 1'b1;
          end else begin
            w_state   = ST_PULSE;
            w_cnt     = PULSE_LD;
            w_prog_en = 1'b1;
          end
        end
        ST_PULSE: begin
          w_rem     = r_rem - CNT_ONE;
          w_prog_en = 1'b0;
          if (r_rem == CNT_ONE) begin
            w_to_rel = 1'b1;
          end else begin
            w_state = ST_GAP;
            w_cnt   = GAP_LD;
          end
        end
        ST_GAP: begin
          w_state   = ST_PULSE;
          w_cnt     = PULSE_LD;
          w_prog_en = 1'b1;
        end
        ST_RELEASE: begin
          w_state = ST_IDLE;
          w_busy  = 1'b0;
          w_done  = 1'b1;
        end
        default: begin
          w_state = ST_IDLE;
        end
      endcase
    end

    // Selects and prog_en drop together, so the pulse never outlives its address.
    if (w_to_rel) begin
      w_state   = ST_RELEASE;
      w_cnt     = RELEASE_LD;
      w_row_sel = '0;
      w_col_sel = '0;
      w_prog_en = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_rem     <= '0;
      r_row_sel <= '0;
      r_col_sel <= '0;
      r_prog_en <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_state;
      r_cnt     <= w_cnt;
      r_rem     <= w_rem;
      r_row_sel <= w_row_sel;
      r_col_sel <= w_col_sel;
      r_prog_en <= w_prog_en;
      r_busy    <= w_busy;
      r_done    <= w_done;
      r_err     <= w_err;
    end
  end

  assign bus.cmd_ready = (r_state == ST_IDLE);
  assign bus.row_sel   = r_row_sel;
  assign bus.col_sel   = r_col_sel;
  assign bus.prog_en   = r_prog_en;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.err       = r_err;

endmodule

// File: tb/tb_fabric_prog_seq.sv
// Testbench for fabric_prog_seq: directed scenarios plus randomized commands,
// compared every cycle against a timeline model of the command.
module tb_fabric_prog_seq;
  import fabric_prog_pkg::*;

  localparam int SU = DEF_SETUP_CYC;
  localparam int PU = DEF_PULSE_CYC;
  localparam int GA = DEF_GAP_CYC;
  localparam int RE = DEF_RELEASE_CYC;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   model_err = 1'b0;

  fabric_prog_seq_if bus();

  fabric_prog_seq #(
    .SETUP_CYC   (SU),
    .PULSE_CYC   (PU),
    .GAP_CYC     (GA),
    .RELEASE_CYC (RE)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // {row_sel, col_sel, prog_en, busy, done, err, cmd_ready}
  function automatic logic [31:0] pack(input logic [6:0] rs, input logic [6:0] cs,
                                       input logic pe, input logic bz, input logic dn,
                                       input logic er, input logic rd);
    return {13'd0, rs, cs, pe, bz, dn, er, rd};
  endfunction

  function automatic logic [31:0] obs();
    return {13'd0, bus.row_sel, bus.col_sel, bus.prog_en, bus.busy, bus.done, bus.err, bus.cmd_ready};
  endfunction

  // Edge index (0 = accept edge) at which the selects drop.
  function automatic int sel_end_of(input int n, input int ab);
    int e;
    e = SU + ((n == 0) ? 0 : (n * PU + (n - 1) * GA));
    if (ab > 0 && ab < e) e = ab;
    return e;
  endfunction

  // Expected outputs just after edge s of a valid command.
  function automatic logic [31:0] model_at(input int s, input int row, input int col,
                                           input int n, input int ab);
    int e;
    int t;
    logic [6:0] rs;
    logic [6:0] cs;
    logic pe;
    e  = sel_end_of(n, ab);
    t  = e + RE;
    rs = '0;
    cs = '0;
    pe = 1'b0;
    if (s < e) begin
      rs = 7'd1 << row;
      cs = 7'd1 << col;
      if (s >= SU && ((s - SU) % (PU + GA)) < PU) pe = 1'b1;
    end
    return pack(rs, cs, pe, s < t, s == t, model_err, s >= t);
  endfunction

  // Issue one command; ab = edge index at which abort is sampled (-1: none);
  // keep_valid holds cmd_valid with garbage operands; stop_at ends the task early.
  task automatic run_cmd(input int row, input int col, input int n, input int ab,
                         input bit keep_valid, input int stop_at);
    int t;
    bus.cmd_row    = 3'(row);
    bus.cmd_col    = 3'(col);
    bus.cmd_npulse = 8'(n);
    bus.cmd_valid  = 1'b1;
    check_eq("ready_before_accept", {31'd0, bus.cmd_ready}, 32'd1);
    @(posedge clk); #1;
    if (!keep_valid) bus.cmd_valid = 1'b0;
    if (row >= N_ROWS || col >= N_COLS) begin
      model_err = 1'b1;
      check_eq($sformatf("reject r%0d c%0d", row, col), obs(), pack('0, '0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1));
      return;
    end
    t = sel_end_of(n, ab) + RE;
    for (int s = 0; s <= t; s++) begin
      if (s > 0) begin
        @(posedge clk); #1;
      end
      check_eq($sformatf("cmd r%0d c%0d n%0d ab%0d s%0d", row, col, n, ab, s), obs(),
               model_at(s, row, col, n, ab));
      if (s == stop_at) return;
      if (s == ab - 1) bus.abort = 1'b1;
      if (s == ab) bus.abort = 1'b0;
      if (keep_valid && s < t) begin
        bus.cmd_row    = 3'($urandom_range(0, 7));
        bus.cmd_col    = 3'($urandom_range(0, 7));
        bus.cmd_npulse = 8'($urandom_range(0, 255));
      end
    end
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      bus.abort = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      check_eq($sformatf("idle %0d", i), obs(), pack('0, '0, 1'b0, 1'b0, 1'b0, model_err, 1'b1));
    end
    bus.abort = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int row;
    int col;
    int n;
    int ab;
    bit kv;
    bus.cmd_valid  = 1'b0;
    bus.cmd_row    = '0;
    bus.cmd_col    = '0;
    bus.cmd_npulse = '0;
    bus.abort      = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check_eq("reset_state", obs(), pack('0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
    rst_n = 1'b1;
    idle(3);

    run_cmd(3, 5, 2, -1, 1'b0, -1);
    idle(2);
    run_cmd(0, 0, 0, -1, 1'b0, -1);
    idle(2);
    run_cmd(7, 2, 0, -1, 1'b0, -1);
    idle(2);
    run_cmd(1, 6, 1, -1, 1'b0, -1);
    idle(1);
    run_cmd(2, 4, 5, SU + PU + GA + 5, 1'b0, -1);
    idle(2);

    run_cmd(6, 0, 1, -1, 1'b1, -1);
    run_cmd(4, 4, 2, -1, 1'b1, -1);
    run_cmd(5, 1, 0, -1, 1'b0, -1);
    idle(2);

    run_cmd(3, 5, 2, -1, 1'b0, SU + 5);
    rst_n = 1'b0;
    @(posedge clk); #1;
    model_err = 1'b0;
    check_eq("reset_mid_pulse", obs(), pack('0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
    rst_n = 1'b1;
    idle(2);

    for (int k = 0; k < 25; k++) begin
      row = $urandom_range(0, 7);
      col = $urandom_range(0, 7);
      n   = $urandom_range(0, 3);
      ab  = -1;
      if ($urandom_range(0, 3) == 0) ab = $urandom_range(1, sel_end_of(n, -1) - 1);
      kv  = 1'($urandom_range(0, 1));
      run_cmd(row, col, n, ab, kv, -1);
      if (!kv) idle($urandom_range(0, 2));
    end
    bus.cmd_valid = 1'b0;
    idle(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
